// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage sign-magnitude compare/select unit (FLT/FLE/FEQ/FGT/FMIN/FMAX); latency 2 cycles.
// Backpressure: S2 holds while out_ready=0; in_ready falls only when both stages are occupied and stalled.
module fcmp_pipe #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [31:0]      a,
   input  logic [31:0]      b,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      res,
   output logic [TAG_W-1:0] tag_out,
   output logic             bad_op
);

   localparam logic [2:0] OP_FLT  = 3'd0;
   localparam logic [2:0] OP_FLE  = 3'd1;
   localparam logic [2:0] OP_FEQ  = 3'd2;
   localparam logic [2:0] OP_FGT  = 3'd3;
   localparam logic [2:0] OP_FMIN = 3'd4;
   localparam logic [2:0] OP_FMAX = 3'd5;

   typedef struct packed {
      logic [2:0]       op;
      logic [TAG_W-1:0] tag;
      logic [31:0]      a;
      logic [31:0]      b;
   } s1_t;

   s1_t         s1_dat;
   logic        s1_vld;
   logic        s2_vld;
   logic        s2_adv;
   logic        sa;
   logic        sb;
   logic [30:0] ma;
   logic [30:0] mb;
   logic        lt;
   logic        eq;
   logic [31:0] nxt_res;
   logic        nxt_bad;

   assign s2_adv    = out_ready | ~s2_vld;
   assign in_ready  = ~s1_vld | s2_adv;
   assign out_valid = s2_vld;

   assign sa = s1_dat.a[31];
   assign sb = s1_dat.b[31];
   assign ma = s1_dat.a[30:0];
   assign mb = s1_dat.b[30:0];
   assign eq = (s1_dat.a == s1_dat.b);

   // Raw sign-magnitude order: -0 sits below +0, NaN/Inf are just bit patterns.
   always_comb begin
      lt = 1'b0;
      if (sa != sb)
         lt = sa;
      else if (sa)
         lt = (ma > mb);
      else
         lt = (ma < mb);
   end

   always_comb begin
      nxt_res = '0;
      nxt_bad = 1'b0;
      case (s1_dat.op)
         OP_FLT:  nxt_res = {31'b0, lt};
         OP_FLE:  nxt_res = {31'b0, lt | eq};
         OP_FEQ:  nxt_res = {31'b0, eq};
         OP_FGT:  nxt_res = {31'b0, ~lt & ~eq};
         OP_FMIN: nxt_res = lt ? s1_dat.a : s1_dat.b;
         OP_FMAX: nxt_res = lt ? s1_dat.b : s1_dat.a;
         default: nxt_bad = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1_vld  <= 1'b0;
         s2_vld  <= 1'b0;
         res     <= '0;
         tag_out <= '0;
         bad_op  <= 1'b0;
      end else begin
         if (in_ready)
            s1_vld <= in_valid;
         if (s2_adv)
            s2_vld <= s1_vld;
         if (s2_adv && s1_vld) begin
            res     <= nxt_res;
            tag_out <= s1_dat.tag;
            bad_op  <= nxt_bad;
         end
      end
   end

   // Payload needs no reset; s1_vld qualifies it.
   always_ff @(posedge clk) begin
      if (in_ready && in_valid) begin
         s1_dat.op  <= op;
         s1_dat.tag <= tag_in;
         s1_dat.a   <= a;
         s1_dat.b   <= b;
      end
   end

endmodule

// File: tb/tb_fcmp_pipe.sv
// Bench for fcmp_pipe: directed vectors, streaming, backpressure, random traffic and mid-flight reset.
module tb_fcmp_pipe;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic [4:0]  tag_in = 5'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] res;
   logic [4:0]  tag_out;
   logic        bad_op;

   int total = 0;
   int passed = 0;
   logic [37:0] exp_q [$];

   typedef struct packed {
      logic [2:0]  o;
      logic [31:0] x;
      logic [31:0] y;
      logic [4:0]  t;
      logic [31:0] r;
      logic        bo;
   } vec_t;

   always #5 clk = ~clk;

   fcmp_pipe #(.TAG_W(5)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .tag_in(tag_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .tag_out(tag_out), .bad_op(bad_op)
   );

   // Map a sign-magnitude word onto a signed integer line; -0 lands at -1, +0 at 0.
   function automatic longint key(input logic [31:0] x);
      longint m;
      m = {33'b0, x[30:0]};
      return x[31] ? (-m - 1) : m;
   endfunction

   function automatic logic [37:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                         input logic [4:0] t);
      logic        lt;
      logic        eq;
      logic [31:0] r;
      logic        bo;
      lt = (key(x) < key(y));
      eq = (x === y);
      r  = 32'd0;
      bo = 1'b0;
      case (o)
         3'd0: r = {31'b0, lt};
         3'd1: r = {31'b0, lt | eq};
         3'd2: r = {31'b0, eq};
         3'd3: r = {31'b0, ~(lt | eq)};
         3'd4: r = lt ? x : y;
         3'd5: r = lt ? y : x;
         default: bo = 1'b1;
      endcase
      return {bo, t, r};
   endfunction

   task automatic gen_ops(output logic [31:0] x, output logic [31:0] y);
      logic [31:0] sp [0:5];
      sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h3F800000};
      case ($urandom_range(0, 4))
         0: begin x = $urandom; y = $urandom; end
         1: begin x = $urandom; y = x; end
         2: begin x = $urandom; y = x ^ 32'h80000000; end
         3: begin x = $urandom; y = {x[31], x[30:0] ^ (31'd1 << $urandom_range(0, 30))}; end
         default: begin x = sp[$urandom_range(0, 5)]; y = sp[$urandom_range(0, 5)]; end
      endcase
   endtask

   // One cycle: drive after the falling edge, sample before the next rising edge.
   task automatic step(input logic v, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] t, input logic ordy,
                       output logic acc, output logic dlv, output logic [31:0] r,
                       output logic [4:0] tg, output logic bo, output logic ov);
      @(negedge clk);
      in_valid  = v;
      op        = o;
      a         = x;
      b         = y;
      tag_in    = t;
      out_ready = ordy;
      #1;
      acc = in_valid & in_ready;
      ov  = out_valid;
      dlv = out_valid & out_ready;
      r   = res;
      tg  = tag_out;
      bo  = bad_op;
      if (acc)
         exp_q.push_back(model(o, x, y, t));
   endtask

   function automatic logic [37:0] pop_exp();
      if (exp_q.size() == 0)
         return 'x;
      return exp_q.pop_front();
   endfunction

   task automatic test_reset();
      rstn      = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1)  $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
      total++; if (res !== 32'd0)      $display("FAIL reset_res got %h want 0", res); else passed++;
      total++; if (tag_out !== 5'd0)   $display("FAIL reset_tag got %h want 0", tag_out); else passed++;
      total++; if (bad_op !== 1'b0)    $display("FAIL reset_bad_op got %b want 0", bad_op); else passed++;
      exp_q.delete();
   endtask

   task automatic test_directed();
      vec_t vt [0:15];
      logic acc, dlv, ov, bo;
      logic [31:0] r;
      logic [4:0] tg;
      logic [37:0] e;
      int lat;
      vt[0]  = '{3'd0, 32'h3F800000, 32'h40000000, 5'd3,  32'd1,        1'b0};
      vt[1]  = '{3'd3, 32'h3F800000, 32'h40000000, 5'd4,  32'd0,        1'b0};
      vt[2]  = '{3'd0, 32'hC0000000, 32'hBF800000, 5'd5,  32'd1,        1'b0};
      vt[3]  = '{3'd1, 32'hBF800000, 32'hBF800000, 5'd6,  32'd1,        1'b0};
      vt[4]  = '{3'd2, 32'h00000000, 32'h80000000, 5'd7,  32'd0,        1'b0};
      vt[5]  = '{3'd4, 32'h80000000, 32'h00000000, 5'd8,  32'h80000000, 1'b0};
      vt[6]  = '{3'd5, 32'hC0400000, 32'h3F000000, 5'd9,  32'h3F000000, 1'b0};
      vt[7]  = '{3'd6, 32'h12345678, 32'h9ABCDEF0, 5'd10, 32'd0,        1'b1};
      vt[8]  = '{3'd0, 32'h80000000, 32'h00000000, 5'd11, 32'd1,        1'b0};
      vt[9]  = '{3'd4, 32'h00000000, 32'h80000000, 5'd12, 32'h80000000, 1'b0};
      vt[10] = '{3'd2, 32'h40490FDB, 32'h40490FDB, 5'd13, 32'd1,        1'b0};
      vt[11] = '{3'd3, 32'h7FC00000, 32'h7F800000, 5'd14, 32'd1,        1'b0};
      vt[12] = '{3'd0, 32'hFFC00000, 32'hFF800000, 5'd15, 32'd1,        1'b0};
      vt[13] = '{3'd5, 32'hC0000000, 32'hBF800000, 5'd16, 32'hBF800000, 1'b0};
      vt[14] = '{3'd7, 32'h00000000, 32'h00000000, 5'd31, 32'd0,        1'b1};
      vt[15] = '{3'd1, 32'h40000000, 32'h3F800000, 5'd17, 32'd0,        1'b0};
      for (int i = 0; i < 16; i++) begin
         step(1'b1, vt[i].o, vt[i].x, vt[i].y, vt[i].t, 1'b1, acc, dlv, r, tg, bo, ov);
         total++; if (acc !== 1'b1) $display("FAIL dir_accept[%0d] got %b want 1", i, acc); else passed++;
         lat = 0;
         dlv = 1'b0;
         while (!dlv && lat < 6) begin
            step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc, dlv, r, tg, bo, ov);
            lat++;
         end
         total++;
         if (!dlv || lat != 2) $display("FAIL dir_latency[%0d] got %0d (dlv=%b) want 2", i, lat, dlv);
         else passed++;
         if (dlv) begin
            e = pop_exp();
            total++;
            if ({bo, tg, r} !== {vt[i].bo, vt[i].t, vt[i].r})
               $display("FAIL dir_result[%0d] got bad=%b tag=%0d res=%h want bad=%b tag=%0d res=%h",
                        i, bo, tg, r, vt[i].bo, vt[i].t, vt[i].r);
            else passed++;
         end
      end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      logic acc, dlv, ov, bo;
      logic [31:0] r, x, y;
      logic [4:0] tg;
      logic [37:0] e;
      int n_acc, got, first;
      n_acc = 0;
      got   = 0;
      first = -1;
      for (int k = 0; k < 20 && got < 8; k++) begin
         gen_ops(x, y);
         step(k < 8, 3'($urandom_range(0, 7)), x, y, 5'(k), 1'b1, acc, dlv, r, tg, bo, ov);
         if (acc) n_acc++;
         if (dlv) begin
            if (first < 0) first = k;
            e = pop_exp();
            total++;
            if ({bo, tg, r} !== e)
               $display("FAIL b2b_result[%0d] got %h want %h", got, {bo, tg, r}, e);
            else passed++;
            total++;
            if (k != first + got) $display("FAIL b2b_gap[%0d] got cycle %0d want %0d", got, k, first + got);
            else passed++;
            got++;
         end
      end
      total++; if (n_acc != 8) $display("FAIL b2b_accepted got %0d want 8", n_acc); else passed++;
      total++; if (got != 8)   $display("FAIL b2b_delivered got %0d want 8", got); else passed++;
      total++; if (first != 2) $display("FAIL b2b_first_cycle got %0d want 2", first); else passed++;
      exp_q.delete();
   endtask

   task automatic test_backpressure();
      logic acc, dlv, ov, bo;
      logic [31:0] r;
      logic [4:0] tg;
      logic [2:0] po [0:2];
      logic [31:0] px [0:2];
      logic [31:0] py [0:2];
      logic [37:0] held, e;
      bit have;
      int idx, got;
      for (int i = 0; i < 3; i++) begin
         po[i] = 3'($urandom_range(0, 5));
         gen_ops(px[i], py[i]);
      end
      idx  = 0;
      have = 1'b0;
      held = 'x;
      acc  = 1'b0;
      ov   = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step(idx < 3, po[idx % 3], px[idx % 3], py[idx % 3], 5'(10 + idx % 3), 1'b0,
              acc, dlv, r, tg, bo, ov);
         if (acc) idx++;
         if (ov) begin
            if (have) begin
               total++;
               if ({bo, tg, r} !== held) $display("FAIL bp_hold[%0d] got %h want %h", k, {bo, tg, r}, held);
               else passed++;
            end
            held = {bo, tg, r};
            have = 1'b1;
         end
      end
      total++; if (idx != 2)     $display("FAIL bp_accepted got %0d want 2", idx); else passed++;
      total++; if (acc !== 1'b0) $display("FAIL bp_in_ready got %b want 0", acc); else passed++;
      total++; if (ov !== 1'b1)  $display("FAIL bp_out_valid got %b want 1", ov); else passed++;
      got = 0;
      for (int k = 0; k < 12 && got < 3; k++) begin
         step(idx < 3, po[idx % 3], px[idx % 3], py[idx % 3], 5'(10 + idx % 3), 1'b1,
              acc, dlv, r, tg, bo, ov);
         if (acc) idx++;
         if (dlv) begin
            e = pop_exp();
            total++;
            if ({bo, tg, r} !== e || tg !== 5'(10 + got))
               $display("FAIL bp_drain[%0d] got %h want %h (tag %0d)", got, {bo, tg, r}, e, 10 + got);
            else passed++;
            got++;
         end
      end
      total++;
      if (got != 3 || idx != 3) $display("FAIL bp_count got delivered=%0d accepted=%0d want 3/3", got, idx);
      else passed++;
      exp_q.delete();
   endtask

   task automatic test_random();
      logic acc, dlv, ov, bo, ordy, prev_stall;
      logic [31:0] r, x, y;
      logic [4:0] tg;
      logic [37:0] held, e;
      prev_stall = 1'b0;
      held       = 'x;
      for (int k = 0; k < 400; k++) begin
         gen_ops(x, y);
         ordy = ($urandom_range(0, 3) != 0);
         step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), x, y, 5'($urandom), ordy,
              acc, dlv, r, tg, bo, ov);
         if (prev_stall) begin
            total++;
            if (ov !== 1'b1 || {bo, tg, r} !== held)
               $display("FAIL rnd_hold[%0d] got vld=%b %h want vld=1 %h", k, ov, {bo, tg, r}, held);
            else passed++;
         end
         if (dlv) begin
            e = pop_exp();
            total++;
            if ({bo, tg, r} !== e) $display("FAIL rnd_result[%0d] got %h want %h", k, {bo, tg, r}, e);
            else passed++;
         end
         total++;
         if (exp_q.size() > 2) $display("FAIL rnd_inflight[%0d] got %0d want <=2", k, exp_q.size());
         else passed++;
         prev_stall = ov & ~ordy;
         held       = {bo, tg, r};
      end
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
         step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc, dlv, r, tg, bo, ov);
         if (dlv) begin
            e = pop_exp();
            total++;
            if ({bo, tg, r} !== e) $display("FAIL rnd_drain[%0d] got %h want %h", k, {bo, tg, r}, e);
            else passed++;
         end
      end
      total++; if (exp_q.size() != 0) $display("FAIL rnd_leftover got %0d want 0", exp_q.size()); else passed++;
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      logic acc0, acc1, dlv, ov, bo;
      logic [31:0] r, x, y;
      logic [4:0] tg;
      logic [37:0] e;
      int n_ov, lat;
      gen_ops(x, y);
      step(1'b1, 3'd4, x, y, 5'd20, 1'b0, acc0, dlv, r, tg, bo, ov);
      step(1'b1, 3'd5, y, x, 5'd21, 1'b0, acc1, dlv, r, tg, bo, ov);
      total++;
      if ({acc0, acc1} !== 2'b11) $display("FAIL mid_accept got %b want 11", {acc0, acc1}); else passed++;
      @(negedge clk);
      rstn     = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      exp_q.delete();
      n_ov = 0;
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc0, dlv, r, tg, bo, ov);
         if (ov) n_ov++;
      end
      total++; if (n_ov != 0) $display("FAIL mid_stale_out got %0d valid cycles want 0", n_ov); else passed++;
      gen_ops(x, y);
      step(1'b1, 3'd0, x, y, 5'd22, 1'b1, acc0, dlv, r, tg, bo, ov);
      total++; if (acc0 !== 1'b1) $display("FAIL mid_next_accept got %b want 1", acc0); else passed++;
      lat = 0;
      dlv = 1'b0;
      while (!dlv && lat < 6) begin
         step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc0, dlv, r, tg, bo, ov);
         lat++;
      end
      e = pop_exp();
      total++;
      if (!dlv || {bo, tg, r} !== e) $display("FAIL mid_next_result got dlv=%b %h want %h", dlv, {bo, tg, r}, e);
      else passed++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
